// File: rtl/dot_product_engine.sv
// Vector dot product: buffers A/B operands in sync-read RAMs, then streams them through a MUL_LAT-stage multiplier into an accumulator.
// Latency start->res_valid = len+MUL_LAT+2 edges; in_ready is low once the vector is loaded, result is held until res_ready.
module dot_product_engine #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int ACC_W   = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    input  logic              signed_mode,
    input  logic              start,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);
    localparam int PW = 2 * DATA_W + 2;

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic              loaded;
    logic              ready_q;
    logic              mode;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              rd_vld;

    logic [ACC_W-1:0]   pipe [MUL_LAT];
    logic [MUL_LAT-1:0] pipe_vld;
    logic [ACC_W-1:0]   acc;
    logic               acc_ovf;

    logic accept, last_beat, go, go_early, issue_last, drained, res_take;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_beat  = 1'b0;
        go         = 1'b0;
        go_early   = 1'b0;
        issue_last = 1'b0;
        drained    = 1'b0;
        res_take   = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        res_valid  = 1'b0;
        case (state)
            LOAD: begin
                go        = start && loaded;
                // start on a partly loaded vector closes it; the beat offered alongside is refused
                go_early  = start && !loaded && (cnt != '0);
                in_ready  = ready_q && !go_early;
                accept    = in_valid && in_ready;
                last_beat = accept && (in_last || cnt == ADDR_W'(DEPTH - 1));
                if (go || go_early) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy       = 1'b1;
                issue_last = ({1'b0, idx} == len - 1'b1);
                if (issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                drained = !rd_vld && (pipe_vld == '0);
                if (drained) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                res_take  = res_ready;
                if (res_take) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            len     <= '0;
            loaded  <= 1'b0;
            ready_q <= 1'b1;
            idx     <= '0;
            mode    <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) cnt <= cnt + 1'b1;
            if (last_beat) begin
                len     <= {1'b0, cnt} + 1'b1;
                loaded  <= 1'b1;
                ready_q <= 1'b0;
            end
            if (go_early) begin
                len     <= {1'b0, cnt};
                ready_q <= 1'b0;
            end
            if (go || go_early) begin
                mode <= signed_mode;
                idx  <= '0;
            end
            if (state == COMPUTE) idx <= idx + 1'b1;
            if (drained) result <= acc;
            if (res_take) begin
                cnt     <= '0;
                loaded  <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_a[cnt] <= in_a;
            mem_b[cnt] <= in_b;
        end
        rd_a <= mem_a[idx];
        rd_b <= mem_b[idx];
    end

    // One extra bit per operand lets a single signed multiply cover both modes
    logic signed [PW-1:0] op_a, op_b, prod;
    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W-1:0]     addend;
    logic [ACC_W:0]       sum;
    logic                 ovf_step;

    assign op_a     = PW'($signed({mode & rd_a[DATA_W-1], rd_a}));
    assign op_b     = PW'($signed({mode & rd_b[DATA_W-1], rd_b}));
    assign prod     = op_a * op_b;
    assign prod_ext = ACC_W'(prod);
    assign addend   = pipe[MUL_LAT-1];
    assign sum      = {1'b0, acc} + {1'b0, addend};
    assign ovf_step = mode ? ((acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                           : sum[ACC_W];

    always_ff @(posedge clk) begin
        pipe[0] <= prod_ext;
        for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld   <= 1'b0;
            pipe_vld <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
        end else begin
            rd_vld      <= (state == COMPUTE);
            pipe_vld[0] <= rd_vld;
            for (int k = 1; k < MUL_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
            if (go || go_early) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end else if (pipe_vld[MUL_LAT-1]) begin
                acc <= sum[ACC_W-1:0];
                if (ovf_step) acc_ovf <= 1'b1;
            end
        end
    end

    assign ovf = acc_ovf;

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: 40-bit and 32-bit accumulator instances driven in lockstep,
// expected results pushed to per-instance queues at start and popped on the result handshake.
module tb_dot_product_engine;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_last, signed_mode, start, res_ready;
    logic [15:0] in_a, in_b;
    logic        ir40, busy40, rv40, ovf40;
    logic [39:0] res40;
    logic        ir32, busy32, rv32, ovf32;
    logic [31:0] res32;

    dot_product_engine #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .MUL_LAT(MUL_LAT), .ACC_W(40)) dut40 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir40), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .signed_mode(signed_mode), .start(start), .busy(busy40),
        .res_valid(rv40), .res_ready(res_ready), .result(res40), .ovf(ovf40));

    dot_product_engine #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .MUL_LAT(MUL_LAT), .ACC_W(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir32), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .signed_mode(signed_mode), .start(start), .busy(busy32),
        .res_valid(rv32), .res_ready(res_ready), .result(res32), .ovf(ovf32));

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t        q40[$];
    exp_t        q32[$];
    logic [15:0] va[$];
    logic [15:0] vb[$];
    bit          m_loaded;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic        prev40 = 1'b0;
    logic        prev32 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input bit sm, output logic [63:0] r, output logic o);
        logic [63:0] mask, acc, p, s;
        longint      pa, pb;
        mask = (64'd1 << w) - 64'd1;
        acc  = '0;
        o    = 1'b0;
        for (int i = 0; i < va.size(); i++) begin
            pa = sm ? longint'($signed(va[i])) : longint'({48'd0, va[i]});
            pb = sm ? longint'($signed(vb[i])) : longint'({48'd0, vb[i]});
            p  = 64'(pa * pb) & mask;
            s  = acc + p;
            if (sm) begin
                if ((acc[w-1] == p[w-1]) && (s[w-1] != acc[w-1])) o = 1'b1;
            end else if (s[w]) begin
                o = 1'b1;
            end
            acc = s & mask;
        end
        r = acc;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rv40 && !prev40 && q40.size() > 0) check("lat40", 64'(cyc - start_cyc), 64'(q40[0].lat));
        if (rv32 && !prev32 && q32.size() > 0) check("lat32", 64'(cyc - start_cyc), 64'(q32[0].lat));
        if (rv40 && res_ready) begin
            if (q40.size() == 0) check("spurious40", 64'(rv40), 64'd0);
            else begin
                e = q40.pop_front();
                check("res40", 64'(res40), e.res);
                check("ovf40", 64'(ovf40), 64'(e.ovf));
            end
        end
        if (rv32 && res_ready) begin
            if (q32.size() == 0) check("spurious32", 64'(rv32), 64'd0);
            else begin
                e = q32.pop_front();
                check("res32", 64'(res32), e.res);
                check("ovf32", 64'(ovf32), 64'(e.ovf));
            end
        end
        prev40 <= rv40;
        prev32 <= rv32;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit last);
        bit acc;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        check("in_ready40", 64'(ir40), 64'(!m_loaded));
        check("in_ready32", 64'(ir32), 64'(!m_loaded));
        acc = !m_loaded;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        if (acc) begin
            va.push_back(a);
            vb.push_back(b);
            if (last || va.size() == 16) m_loaded = 1'b1;
        end
    endtask

    task automatic do_start(input bit sm, input bit expect_run);
        exp_t        e;
        logic [63:0] r;
        logic        o;
        signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        if (expect_run) begin
            e.lat = va.size() + MUL_LAT + 2;
            model(40, sm, r, o); e.res = r; e.ovf = o; q40.push_back(e);
            model(32, sm, r, o); e.res = r; e.ovf = o; q32.push_back(e);
        end
        va.delete(); vb.delete(); m_loaded = 1'b0;
    endtask

    task automatic wait_results();
        int n = 0;
        while ((q40.size() != 0 || q32.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(q40.size() + q32.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 64'(ir40), 64'd1);
        check({tag, "_busy"},     64'(busy40), 64'd0);
        check({tag, "_res_valid"}, 64'(rv40), 64'd0);
        check({tag, "_result"},   64'(res40), 64'd0);
        check({tag, "_ovf"},      64'(ovf40), 64'd0);
        check({tag, "_result32"}, 64'(res32), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
        signed_mode = 1'b0; start = 1'b0; res_ready = 1'b1; m_loaded = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;

        // 1: small signed vector, latency 4+3+2
        send(16'd1, 16'd5, 0); send(16'd2, 16'd6, 0); send(16'd3, 16'd7, 0); send(16'd4, 16'd8, 1);
        do_start(1, 1);
        wait_results();

        // 2: mixed-sign signed operands
        send(16'hFFFD, 16'h0002, 0); send(16'h7FFF, 16'hFFFF, 1);
        do_start(1, 1);
        wait_results();

        // 3: full-depth unsigned, the 17th beat must be refused
        for (int k = 0; k < 16; k++) send(16'hFFFF, 16'hFFFF, 0);
        send(16'h1234, 16'h1234, 0);
        do_start(0, 1);
        wait_results();

        // 4: result held under backpressure
        send(16'd10, 16'd3, 0); send(16'd20, 16'd4, 1);
        res_ready = 1'b0;
        do_start(1, 1);
        n = 0;
        while (!rv40 && n < 100) begin @(negedge clk); n++; end
        check("t4_res_valid", 64'(rv40), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_result", 64'(res40), q40[0].res);
            check("t4_hold_in_ready", 64'(ir40), 64'd0);
            check("t4_hold_busy", 64'(busy40), 64'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        check("t4_res_valid_low", 64'(rv40), 64'd0);
        check("t4_in_ready_high", 64'(ir40), 64'd1);
        send(16'd7, 16'd6, 1);
        do_start(1, 1);
        wait_results();

        // 5: start with nothing loaded, then an unterminated 3-element vector
        do_start(1, 0);
        @(negedge clk);
        check("t5_empty_busy", 64'(busy40), 64'd0);
        check("t5_empty_in_ready", 64'(ir40), 64'd1);
        @(posedge clk); #1;
        send(16'd2, 16'd5, 0); send(16'd3, 16'd5, 0); send(16'd4, 16'd5, 0);
        do_start(1, 1);
        wait_results();

        // reset in the middle of a computation
        send(16'd5, 16'd1, 0); send(16'd6, 16'd1, 0); send(16'd7, 16'd1, 1);
        do_start(1, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        @(posedge clk); #1;
        send(16'd2, 16'd4, 0); send(16'd3, 16'd5, 1);
        do_start(0, 1);
        wait_results();

        // 6: signed overflow in the 32-bit instance, then cleared by the next run
        send(16'h8000, 16'h8000, 0); send(16'h8000, 16'h8000, 1);
        do_start(1, 1);
        wait_results();
        send(16'd1, 16'd1, 1);
        do_start(1, 1);
        wait_results();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
